frame_packer: RTL

FRAME_PACKER -- requirements
Module: frame_packer

---
 rtl/frame_pkg.sv | 19 +
 rtl/frame_packer_bit_deserializer.sv | 51 +++++
 rtl/frame_packer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: shared types and defaults for the frame packer.
//   state_t         - packer FSM state encoding (also exposed on fsm_state)
//   byte_t          - one packed video byte
//   FRAME_BYTES_DEF - bytes per frame (320x240 1-bit pixels)
//   ADDR_W_DEF      - frame-buffer byte-address width
package frame_pkg;

  localparam int FRAME_BYTES_DEF = 9600;
  localparam int ADDR_W_DEF      = 14;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/frame_packer_bit_deserializer.sv
// bit_deserializer: collects MSB-first serial bits into bytes.
// Ports:
//   CLK_40     in  system clock (rising edge)
//   reset_n    in  synchronous active-low reset
//   clear      in  drop any partial byte (wins over bit_valid)
//   enable     in  accept bits only while high
//   bit_valid  in  strobe: bit_in is a new bit
//   bit_in     in  serial data bit
//   byte_valid out one-cycle pulse, byte_data holds a complete byte
//   byte_data  out completed byte, first received bit in bit 7
module bit_deserializer
  import frame_pkg::*;
(
  input  logic       CLK_40,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  // Only seven bits need storing: the eighth goes straight into byte_data.
  logic [6:0] shift_q;
  logic [2:0] bit_cnt_q;

  always_ff @(posedge CLK_40) begin
    if (!reset_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else if (clear) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (enable && bit_valid) begin
        shift_q   <= {shift_q[5:0], bit_in};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= byte_t'({shift_q, bit_in});
        end
      end
    end
  end

endmodule

// File: rtl/frame_packer.sv
// frame_packer: packs a serial 1-bit video stream into bytes and writes them
// to a frame-buffer RAM, one frame of FRAME_BYTES bytes at a time.
// Optional feature: define FRAME_PACKER_PINGPONG_EN for double-buffered
// banking (wr_bank toggles per frame, disp_bank gets the finished bank).
// Ports:
//   CLK_40      in  system clock (rising edge)
//   reset_n     in  synchronous active-low reset
//   bit_valid   in  strobe for bit_in
//   bit_in      in  serial video bit, MSB-first
//   frame_start in  arm / restart packing at byte 0
//   wr_en       out write request valid
//   wr_addr     out byte address of the request
//   wr_data     out packed byte
//   wr_ready    in  RAM accepts the request this cycle
//   wr_bank     out bank being written
//   disp_bank   out bank released for display
//   frame_done  out one-cycle pulse per completed frame
//   frame_count out completed frames, wrapping
//   overflow    out sticky: a completed byte was dropped
//   fsm_state   out current FSM state (debug)
// Handshake: a write transfers on a rising edge where wr_en && wr_ready;
// wr_en/wr_addr/wr_data hold steady until then and wr_en never depends on
// wr_ready.
module frame_packer
  import frame_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              CLK_40,
  input  logic              reset_n,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              frame_start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready,
  output logic              wr_bank,
  output logic              disp_bank,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              overflow,
  output logic [1:0]        fsm_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  // Index arithmetic wraps at the frame length so an address can never
  // run past the last byte, even when bytes are dropped.
  function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] i);
    return (i == LAST_ADDR) ? '0 : i + ADDR_W'(1);
  endfunction

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_acc;
  logic              accept;
  logic              byte_valid;
  byte_t             byte_data;

  assign fsm_state = state_q;

  bit_deserializer u_deser (
    .CLK_40     (CLK_40),
    .reset_n    (reset_n),
    .clear      (frame_start),
    .enable     (state_q != ST_IDLE),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  assign accept  = wr_en & wr_ready;
  // Byte index after this cycle's acceptance, used for a byte loading now.
  assign idx_acc = accept ? next_idx(idx_q) : idx_q;

  always_ff @(posedge CLK_40) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else if (frame_start) begin
      // Restart: pending write cancelled, no frame_done for the partial frame.
      state_q    <= ST_FILL;
      idx_q      <= '0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state_q != ST_IDLE) begin
        if (byte_valid && wr_en && !wr_ready) begin
          // Holding register still busy: drop the new byte but keep its slot.
          overflow <= 1'b1;
          idx_q    <= next_idx(idx_q);
        end else if (byte_valid) begin
          wr_en   <= 1'b1;
          wr_addr <= idx_acc;
          wr_data <= byte_data;
          idx_q   <= idx_acc;
        end else begin
          idx_q <= idx_acc;
          if (accept) wr_en <= 1'b0;
        end

        if (state_q == ST_DONE) begin
          state_q <= ST_FILL;
        end else if (accept && wr_addr == LAST_ADDR) begin
          state_q     <= ST_DONE;
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

`ifdef FRAME_PACKER_PINGPONG_EN
  // Swap banks on the DONE cycle: the finished bank goes to display.
  always_ff @(posedge CLK_40) begin
    if (!reset_n) begin
      wr_bank   <= 1'b0;
      disp_bank <= 1'b1;
    end else if (state_q == ST_DONE) begin
      disp_bank <= wr_bank;
      wr_bank   <= ~wr_bank;
    end
  end
`else
  assign wr_bank   = 1'b0;
  assign disp_bank = 1'b0;
`endif

endmodule
